// File: rtl/matmul_input_mem_responder.sv
// Operand memory responder for the systolic top's input-RAM read port.
// Host-loaded word array with a fixed-latency, fully pipelined read path and a load-ready flag.
`ifndef MEM_PORT_WIDTH
`define MEM_PORT_WIDTH 32
`endif
`ifndef MEM_ACCESS_LATENCY
`define MEM_ACCESS_LATENCY 3
`endif

module matmul_input_mem_responder #(
    parameter int unsigned MEM_PORT_WIDTH     = `MEM_PORT_WIDTH,
    parameter int unsigned DEPTH              = 1024,
    parameter int unsigned MEM_ACCESS_LATENCY = `MEM_ACCESS_LATENCY
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      host_wr_en,
    input  logic [31:0]               host_addr,
    input  logic [MEM_PORT_WIDTH-1:0] host_wr_data,
    input  logic                      host_load_done,
    input  logic [31:0]               mem_addr,
    input  logic                      mem_wr_en,
    output logic [MEM_PORT_WIDTH-1:0] mem_rd_data,
    output logic                      inputs_rdy,
    output logic                      addr_err,
    output logic [31:0]               rd_count
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic {
        LOADING,
        READY
    } state_t;

    state_t state, state_nxt;

    logic [MEM_PORT_WIDTH-1:0] mem [DEPTH];

    logic        fin_vld;
    logic [31:0] fin_addr;
    logic        fin_in_range;
    logic        host_in_range;

    assign host_in_range = (host_addr < DEPTH_W);
    assign fin_in_range  = (fin_addr < DEPTH_W);

    // The output register is the last of the L stages, so only L-1 request
    // stages precede the array read; L=1 reads straight from the port.
    generate
        if (MEM_ACCESS_LATENCY <= 1) begin : g_direct
            always_comb begin
                fin_vld  = ~mem_wr_en;
                fin_addr = mem_addr;
            end
        end else begin : g_pipe
            localparam int unsigned PD = MEM_ACCESS_LATENCY - 1;
            logic [PD-1:0]       vld_q;
            logic [PD-1:0][31:0] addr_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q  <= '0;
                    addr_q <= '0;
                end else begin
                    vld_q[0]  <= ~mem_wr_en;
                    addr_q[0] <= mem_addr;
                    for (int unsigned i = 1; i < PD; i++) begin
                        vld_q[i]  <= vld_q[i-1];
                        addr_q[i] <= addr_q[i-1];
                    end
                end
            end

            always_comb begin
                fin_vld  = vld_q[PD-1];
                fin_addr = addr_q[PD-1];
            end
        end
    endgenerate

    // Array writes live in their own block so the read below sees pre-write data.
    always_ff @(posedge clk) begin
        if (!rst && host_wr_en && host_in_range) begin
            mem[host_addr[AW-1:0]] <= host_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_data <= '0;
            rd_count    <= '0;
            addr_err    <= 1'b0;
        end else begin
            mem_rd_data <= '0;
            if (fin_vld && fin_in_range) begin
                mem_rd_data <= mem[fin_addr[AW-1:0]];
                if (rd_count != '1) begin
                    rd_count <= rd_count + 32'd1;
                end
            end
            if ((fin_vld && !fin_in_range) || (host_wr_en && !host_in_range)) begin
                addr_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOADING;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        inputs_rdy = 1'b0;
        case (state)
            LOADING: begin
                if (host_load_done) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                inputs_rdy = 1'b1;
                if (host_wr_en && !host_load_done) begin
                    state_nxt = LOADING;
                end
            end
            default: state_nxt = LOADING;
        endcase
    end

endmodule
